io_uart_tx: RTL
===============

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, 16'd868, reset value of the baud divisor in clock cycles per bit.
REQ-002 Parameter FIFO_DEPTH, 8, transmit FIFO depth in bytes; power of two, 2..16.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 io_addr  input  32  IO address from the system bus; only bits [3:2] decoded, all other bits ignored.
REQ-006 io_write_data  input  32  write data from the system bus.
REQ-007 io_write_en  input  1  write strobe from the system bus (already device-gated); one write per high cycle.
REQ-008 io_read_data  output  32  combinational read data for the current io_addr.
REQ-009 tx  output  1  serial line: idle high, 8N1 frames, LSB first.
REQ-010 irq  output  1  level interrupt; high when FIFO empty and transmitter idle.

Function
REQ-011 Register map by io_addr[3:2]: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 COUNT.
REQ-012 TXDATA write: push io_write_data[7:0] into FIFO; read returns 32'h0.
REQ-013 STATUS read = {28'h0, overflow, busy, full, empty} (bit0 empty, bit1 full, bit2 busy, bit3 overflow).
REQ-014 STATUS write with io_write_data[3]=1 clears overflow; other bits ignored.
REQ-015 DIVISOR read = {16'h0, divisor}; write loads io_write_data[15:0]; written value 0 stored as 1.
REQ-016 COUNT read = FIFO occupancy, zero-extended to 32 bits (range 0..FIFO_DEPTH).
REQ-017 io_read_data purely combinational from io_addr and current register state; no read side effects.
REQ-018 Push when occupancy (pre-edge) == FIFO_DEPTH: byte dropped, overflow set, FIFO unchanged, even if a pop occurs the same cycle.
REQ-019 Simultaneous push and pop with occupancy < FIFO_DEPTH: both performed, occupancy unchanged.
REQ-020 FIFO pointers wrap modulo FIFO_DEPTH; order strictly first-in-first-out.
REQ-021 FSM states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-022 IDLE: tx=1; if FIFO non-empty at an edge, pop head into shift register, latch divisor into frame divisor, enter START.
REQ-023 START: tx=0 for frame-divisor cycles, then DATA.
REQ-024 DATA: tx = shift[0]; after frame-divisor cycles shift right; after 8 bits enter STOP.
REQ-025 STOP: tx=1 for frame-divisor cycles, then IDLE; a queued byte is popped on the next edge (one idle cycle between frames).
REQ-026 Latency: byte written at edge E into empty FIFO with FSM idle is popped at E+1; tx low from E+1 for the full START period.
REQ-027 Frame length exactly 10 x frame-divisor cycles; DIVISOR writes mid-frame affect only later frames.
REQ-028 irq = empty & ~busy, combinational from registered state.

Reset
REQ-029 rst high asynchronously forces: tx=1, state IDLE, FIFO empty (pointers and occupancy 0), overflow 0, divisor=CLKS_PER_BIT, bit counter and baud counter 0.
REQ-030 Reset mid-frame aborts the frame immediately; tx high at once; queued bytes discarded.
REQ-031 Writes during reset are ignored; first write accepted on the first edge after rst deasserts.
REQ-032 After reset: STATUS reads 32'h1, COUNT reads 0, irq=1.

Verification
REQ-033 DIVISOR=4, write TXDATA 0x55 -> tx levels 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 total); busy high 40 cycles; then irq=1.
REQ-034 DIVISOR=4, 10 TXDATA writes on consecutive cycles -> 9 accepted, 10th dropped; COUNT=8, STATUS=32'hE; all 9 bytes transmitted in order.
REQ-035 Overflow set, write STATUS 32'h8 -> STATUS bit3=0; other bits unchanged.
REQ-036 Frame running at DIVISOR=4, write DIVISOR=2 mid-frame -> current frame stays 40 cycles; next frame 20 cycles.
REQ-037 Assert rst 13 cycles into a frame with 3 bytes queued -> tx=1 immediately, COUNT=0, STATUS=32'h1, DIVISOR=CLKS_PER_BIT.
REQ-038 Write DIVISOR=0 -> DIVISOR reads 1; write 0xA5 -> 10-cycle frame with one cycle per bit.

Source files
------------

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO,
// programmable baud divisor, sticky overflow flag and idle interrupt.
module io_uart_tx #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_write_data,
    input  logic        io_write_en,
    output logic [31:0] io_read_data,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DIVISOR = 2'd2;
    localparam logic [1:0] A_COUNT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [15:0]        r_divisor;
    logic [15:0]        r_frame_div;
    logic [15:0]        w_frame_div_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         w_bit_cnt_next;
    logic [15:0]        r_baud_cnt;
    logic [15:0]        w_baud_cnt_next;
    logic               r_tx;
    logic               w_tx_next;

    logic               w_wr_txdata;
    logic               w_wr_status;
    logic               w_wr_divisor;
    logic               w_empty;
    logic               w_full;
    logic               w_busy;
    logic               w_push;
    logic               w_pop;
    logic               w_baud_done;
    logic               w_unused;

    assign w_wr_txdata  = io_write_en && (io_addr[3:2] == A_TXDATA);
    assign w_wr_status  = io_write_en && (io_addr[3:2] == A_STATUS);
    assign w_wr_divisor = io_write_en && (io_addr[3:2] == A_DIVISOR);

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_busy      = (r_state != S_IDLE);
    // A full FIFO drops the byte even when the transmitter pops this cycle.
    assign w_push      = w_wr_txdata && !w_full;
    assign w_baud_done = (r_baud_cnt == (r_frame_div - 16'd1));

    assign tx  = r_tx;
    assign irq = w_empty && !w_busy;

    assign w_unused = ^{io_addr[31:4], io_addr[1:0], io_write_data[31:16]};

    // Register read mux; reads have no side effects.
    always_comb begin
        io_read_data = 32'h0;
        case (io_addr[3:2])
            A_TXDATA:  io_read_data = 32'h0;
            A_STATUS:  io_read_data = {28'h0, r_overflow, w_busy, w_full, w_empty};
            A_DIVISOR: io_read_data = {16'h0, r_divisor};
            A_COUNT:   io_read_data = 32'(r_count);
            default:   io_read_data = 32'h0;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_write_data[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Control registers: sticky overflow and baud divisor (zero is stored as one).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_divisor  <= CLKS_PER_BIT;
        end else begin
            if (w_wr_txdata && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status && io_write_data[3]) begin
                r_overflow <= 1'b0;
            end
            if (w_wr_divisor) begin
                r_divisor <= (io_write_data[15:0] == 16'h0) ? 16'd1 : io_write_data[15:0];
            end
        end
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame_div <= CLKS_PER_BIT;
            r_shift     <= 8'h0;
            r_bit_cnt   <= 3'd0;
            r_baud_cnt  <= 16'd0;
            r_tx        <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_frame_div <= w_frame_div_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_baud_cnt  <= w_baud_cnt_next;
            r_tx        <= w_tx_next;
        end
    end

    // Next-state logic; tx is registered from the level of the state being entered.
    always_comb begin
        w_state_next     = r_state;
        w_frame_div_next = r_frame_div;
        w_shift_next     = r_shift;
        w_bit_cnt_next   = r_bit_cnt;
        w_baud_cnt_next  = r_baud_cnt;
        w_pop            = 1'b0;
        w_tx_next        = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop            = 1'b1;
                    w_shift_next     = r_mem[r_rd_ptr];
                    w_frame_div_next = r_divisor;
                    w_baud_cnt_next  = 16'd0;
                    w_bit_cnt_next   = 3'd0;
                    w_state_next     = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = 16'd0;
                    w_state_next    = S_DATA;
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = 16'd0;
                    w_shift_next    = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_next = 3'd0;
                        w_state_next   = S_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = 16'd0;
                    w_state_next    = S_IDLE;
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule
